// File: rtl/gcd_accel_pkg.sv
// Shared engine definitions: state encoding used by the CPU and the GCD accelerator.
package gcd_accel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } gcd_state_t;

    localparam int unsigned CYCLES_W = 32;
    localparam int unsigned JOBS_W   = 16;

endpackage

// File: rtl/gcd_job_fifo.sv
// Job queue for the GCD engine: registered-output FIFO, no fall-through.
module gcd_job_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when a stored entry leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_accel.sv
// Queued subtractive GCD accelerator with step limit, result hold and job statistics.
module gcd_accel
    import gcd_accel_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_STEPS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             bsy,
    output logic [31:0]      cycles,
    output logic [15:0]      jobs_done
);

    localparam logic [CYCLES_W-1:0] STEP_LIMIT = CYCLES_W'(MAX_STEPS);

    gcd_state_t state, state_next;

    logic [WIDTH-1:0]    a, a_next;
    logic [WIDTH-1:0]    b, b_next;
    logic [CYCLES_W-1:0] steps, steps_next;
    logic [WIDTH-1:0]    gcd_next;
    logic                err_next;
    logic [CYCLES_W-1:0] cycles_next;
    logic [JOBS_W-1:0]   jobs_next;

    logic                pop;
    logic                q_full;
    logic                q_empty;
    logic [2*WIDTH-1:0]  q_dout;

    gcd_job_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    assign in_ready  = !q_full;
    assign out_valid = (state == DONE);
    assign bsy       = (state != IDLE) || !q_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            steps     <= '0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
            cycles    <= '0;
            jobs_done <= '0;
        end else begin
            state     <= state_next;
            a         <= a_next;
            b         <= b_next;
            steps     <= steps_next;
            out_gcd   <= gcd_next;
            out_err   <= err_next;
            cycles    <= cycles_next;
            jobs_done <= jobs_next;
        end
    end

    always_comb begin
        state_next  = state;
        a_next      = a;
        b_next      = b;
        steps_next  = steps;
        gcd_next    = out_gcd;
        err_next    = out_err;
        cycles_next = cycles;
        jobs_next   = jobs_done;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    a_next     = q_dout[2*WIDTH-1:WIDTH];
                    b_next     = q_dout[WIDTH-1:0];
                    steps_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Termination wins over the step limit, so a job needing exactly MAX_STEPS succeeds.
                if (a == b || a == '0 || b == '0) begin
                    state_next  = DONE;
                    cycles_next = steps;
                    err_next    = (a == '0) && (b == '0);
                    gcd_next    = (a == '0) ? b : a;
                end else if (steps == STEP_LIMIT) begin
                    state_next  = DONE;
                    cycles_next = steps;
                    err_next    = 1'b1;
                    gcd_next    = '0;
                end else begin
                    if (a > b) begin
                        a_next = a - b;
                    end else begin
                        b_next = b - a;
                    end
                    steps_next = steps + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    jobs_next  = jobs_done + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_accel.sv
// Self-checking bench for gcd_accel against a quotient-sum Euclid reference model.
module tb_gcd_accel;

    localparam int unsigned W   = 16;
    localparam int unsigned D   = 4;
    localparam int unsigned MS  = 1024;
    localparam int unsigned SD  = 2;
    localparam int unsigned SMS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_gcd;
    logic          out_err;
    logic          bsy;
    logic [31:0]   cycles;
    logic [15:0]   jobs_done;

    logic          s_in_valid = 1'b0;
    logic          s_in_ready;
    logic [W-1:0]  s_in_a = '0;
    logic [W-1:0]  s_in_b = '0;
    logic          s_out_valid;
    logic          s_out_ready = 1'b0;
    logic [W-1:0]  s_out_gcd;
    logic          s_out_err;
    logic          s_bsy;
    logic [31:0]   s_cycles;
    logic [15:0]   s_jobs_done;

    int            total = 0;
    int            bad = 0;
    int unsigned   exp_jobs = 0;
    int unsigned   exp_s_jobs = 0;

    always #5 clk = ~clk;

    gcd_accel #(.WIDTH(W), .DEPTH(D), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
        .bsy(bsy), .cycles(cycles), .jobs_done(jobs_done)
    );

    gcd_accel #(.WIDTH(W), .DEPTH(SD), .MAX_STEPS(SMS)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_gcd(s_out_gcd), .out_err(s_out_err),
        .bsy(s_bsy), .cycles(s_cycles), .jobs_done(s_jobs_done)
    );

    // Subtraction count of the subtractive algorithm equals the sum of Euclid quotients minus one.
    function automatic void model(input int unsigned a, input int unsigned b, input int unsigned max_steps,
                                  output int unsigned g, output logic e, output int unsigned st);
        int unsigned x, y, r;
        g = 0; e = 1'b0; st = 0;
        if (a == 0 && b == 0) begin
            e = 1'b1;
        end else if (a == 0) begin
            g = b;
        end else if (b == 0) begin
            g = a;
        end else begin
            x = a; y = b;
            while (y != 0) begin
                st = st + x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
            st = st - 1;
            if (st > max_steps) begin
                g = 0; e = 1'b1; st = max_steps;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_gcd !== '0) begin bad++; $display("FAIL reset_out_gcd got=%0d want=0", out_gcd); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
        total++; if (cycles !== 32'd0) begin bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
        total++; if (jobs_done !== 16'd0) begin bad++; $display("FAIL reset_jobs_done got=%0d want=0", jobs_done); end
        total++; if (bsy !== 1'b0) begin bad++; $display("FAIL reset_bsy got=%b want=0", bsy); end
        total++; if (s_out_valid !== 1'b0 || s_bsy !== 1'b0) begin bad++; $display("FAIL reset_small got=%b%b want=00", s_out_valid, s_bsy); end
        rst = 1'b0;
        exp_jobs = 0;
        exp_s_jobs = 0;
    endtask

    task automatic test_basic();
        int unsigned g, st, lat;
        logic e;
        model(48, 18, MS, g, e, st);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'd48; in_b = 16'd18;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin lat = i; break; end
        end
        // Push edge precedes the pop edge by one, so valid appears k+2 edges after the push.
        total++; if (lat !== st + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, st + 2); end
        total++; if (out_gcd !== W'(g)) begin bad++; $display("FAIL basic_gcd got=%0d want=%0d", out_gcd, g); end
        total++; if (out_err !== e) begin bad++; $display("FAIL basic_err got=%b want=%b", out_err, e); end
        total++; if (cycles !== st) begin bad++; $display("FAIL basic_cycles got=%0d want=%0d", cycles, st); end
        total++; if (bsy !== 1'b1) begin bad++; $display("FAIL basic_bsy_done got=%b want=1", bsy); end
        @(negedge clk);
        exp_jobs++;
        total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL basic_jobs got=%0d want=%0d", jobs_done, exp_jobs); end
        total++; if (out_valid !== 1'b0 || bsy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b%b want=00", out_valid, bsy); end
    endtask

    task automatic test_zero();
        int unsigned g0, g1, st, n;
        logic e0, e1;
        logic [W-1:0] rg [2];
        logic re [2];
        model(0, 7, MS, g0, e0, st);
        model(0, 0, MS, g1, e1, st);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = '0; in_b = 16'd7;
        @(negedge clk);
        in_a = '0; in_b = '0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && n < 2) begin rg[n] = out_gcd; re[n] = out_err; n++; end
        end
        total++; if (n !== 2) begin bad++; $display("FAIL zero_count got=%0d want=2", n); end
        total++; if (rg[0] !== W'(g0) || re[0] !== e0) begin bad++; $display("FAIL zero_first got=%0d/%b want=%0d/%b", rg[0], re[0], g0, e0); end
        total++; if (rg[1] !== W'(g1) || re[1] !== e1) begin bad++; $display("FAIL zero_second got=%0d/%b want=%0d/%b", rg[1], re[1], g1, e1); end
        exp_jobs += 2;
        total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL zero_jobs got=%0d want=%0d", jobs_done, exp_jobs); end
    endtask

    task automatic test_timeout();
        int unsigned ta [4] = '{1, 9, 1, 1};
        int unsigned tb [4] = '{100, 6, 9, 10};
        int unsigned g, st, lat;
        logic e;
        s_out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            model(ta[j], tb[j], SMS, g, e, st);
            s_in_valid = 1'b1; s_in_a = W'(ta[j]); s_in_b = W'(tb[j]);
            @(negedge clk);
            s_in_valid = 1'b0;
            lat = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (s_out_valid === 1'b1) begin lat = i; break; end
            end
            total++; if (lat !== st + 2) begin bad++; $display("FAIL timeout_latency job=%0d got=%0d want=%0d", j, lat, st + 2); end
            total++; if (s_out_gcd !== W'(g) || s_out_err !== e) begin bad++; $display("FAIL timeout_result job=%0d got=%0d/%b want=%0d/%b", j, s_out_gcd, s_out_err, g, e); end
            if (!e) begin
                total++; if (s_cycles !== st) begin bad++; $display("FAIL timeout_cycles job=%0d got=%0d want=%0d", j, s_cycles, st); end
            end
            @(negedge clk);
            exp_s_jobs++;
            total++; if (s_jobs_done !== 16'(exp_s_jobs)) begin bad++; $display("FAIL timeout_jobs got=%0d want=%0d", s_jobs_done, exp_s_jobs); end
        end
    endtask

    task automatic test_full();
        int unsigned acc, held_bad, n, gbad;
        logic seen;
        out_ready = 1'b0;
        acc = 0; held_bad = 0; seen = 1'b0;
        in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
        for (int i = 0; i < 12; i++) begin
            if (in_ready === 1'b1) acc++;
            if (seen && (out_valid !== 1'b1 || out_gcd !== 16'd5 || out_err !== 1'b0)) held_bad++;
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (acc !== D + 1) begin bad++; $display("FAIL full_accepted got=%0d want=%0d", acc, D + 1); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++; if (seen !== 1'b1 || held_bad !== 0) begin bad++; $display("FAIL full_hold got=%b/%0d want=1/0", seen, held_bad); end
        out_ready = 1'b1;
        n = 0; gbad = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) begin
                n++;
                if (out_gcd !== 16'd5 || out_err !== 1'b0) gbad++;
            end
            @(negedge clk);
        end
        exp_jobs += D + 1;
        total++; if (n !== D + 1 || gbad !== 0) begin bad++; $display("FAIL full_drain got=%0d/%0d want=%0d/0", n, gbad, D + 1); end
        total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL full_jobs got=%0d want=%0d", jobs_done, exp_jobs); end
        total++; if (bsy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL full_idle got=%b%b want=01", bsy, in_ready); end
    endtask

    task automatic test_reset_run();
        int unsigned stale;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'd1000; in_b = 16'd1;
        @(negedge clk);
        in_a = 16'd3; in_b = 16'd3;
        @(negedge clk);
        in_a = 16'd8; in_b = 16'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (out_valid !== 1'b0 || bsy !== 1'b1) begin bad++; $display("FAIL rstrun_running got=%b%b want=01", out_valid, bsy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstrun_out_valid got=%b want=0", out_valid); end
        total++; if (bsy !== 1'b0) begin bad++; $display("FAIL rstrun_bsy got=%b want=0", bsy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstrun_in_ready got=%b want=1", in_ready); end
        total++; if (jobs_done !== 16'd0) begin bad++; $display("FAIL rstrun_jobs got=%0d want=0", jobs_done); end
        rst = 1'b0;
        exp_jobs = 0;
        exp_s_jobs = 0;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || bsy !== 1'b0) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL rstrun_stale got=%0d want=0", stale); end
    endtask

    task automatic test_random();
        localparam int unsigned N = 24;
        int unsigned q_g [$];
        logic        q_e [$];
        int unsigned q_st [$];
        int unsigned pushed, a, b, g, st, eg, est;
        logic e, ee;
        pushed = 0;
        for (int cyc = 0; cyc < 60000 && (pushed < N || q_g.size() != 0); cyc++) begin
            if (pushed < N && $urandom_range(0, 3) != 0) begin
                if (pushed % 8 == 7) begin
                    a = 1; b = $urandom_range(1030, 1500);
                end else if (pushed % 8 == 3) begin
                    a = 0; b = (pushed % 16 == 3) ? 0 : $urandom_range(1, 400);
                end else begin
                    a = $urandom_range(0, 400); b = $urandom_range(0, 400);
                end
                in_valid = 1'b1; in_a = a[W-1:0]; in_b = b[W-1:0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (q_g.size() == 0) begin
                    bad++; $display("FAIL random_unexpected got=%0d/%b want=none", out_gcd, out_err);
                end else begin
                    eg = q_g.pop_front(); ee = q_e.pop_front(); est = q_st.pop_front();
                    if (out_gcd !== W'(eg) || out_err !== ee || (!ee && cycles !== est)) begin
                        bad++; $display("FAIL random_result got=%0d/%b/%0d want=%0d/%b/%0d", out_gcd, out_err, cycles, eg, ee, est);
                    end
                    exp_jobs++;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                model(a, b, MS, g, e, st);
                q_g.push_back(g); q_e.push_back(e); q_st.push_back(st);
                pushed++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (pushed !== N || q_g.size() !== 0) begin bad++; $display("FAIL random_complete got=%0d/%0d want=%0d/0", pushed, q_g.size(), N); end
        total++; if (jobs_done !== 16'(exp_jobs)) begin bad++; $display("FAIL random_jobs got=%0d want=%0d", jobs_done, exp_jobs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_timeout();
        test_full();
        test_reset_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/gcd_accel.md
GCD_ACCEL -- requirements
Module: gcd_accel

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, job-queue entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_STEPS, default 1024, subtraction-step limit per job.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  host offers a job.
REQ-007 SHALL have port in_ready  output  1  queue can accept a job (not full).
REQ-008 SHALL have ports in_a, in_b  input  WIDTH each  job operands.
REQ-009 SHALL have port out_valid  output  1  result held for host.
REQ-010 SHALL have port out_ready  input  1  host accepts result.
REQ-011 SHALL have port out_gcd  output  WIDTH  result.
REQ-012 SHALL have port out_err  output  1  job faulted (0,0 or timeout).
REQ-013 SHALL have port bsy  output  1  engine not IDLE or queue non-empty.
REQ-014 SHALL have port cycles  output  32  steps used by the last completed job.
REQ-015 SHALL have port jobs_done  output  16  results accepted by host, wraps at 2^16.

Function
REQ-016 Job push SHALL occur on an edge with in_valid and in_ready both high; in_ready SHALL be low exactly when DEPTH entries are held.
REQ-017 Queue SHALL be FIFO; push and pop on one edge SHALL be allowed when full or empty-with-push not yet visible (pop only from stored entries; no fall-through).
REQ-018 Engine states SHALL be IDLE, RUN, DONE; encoding from shared package.
REQ-019 IDLE: if queue non-empty, pop head into A,B, clear step count, go RUN.
REQ-020 RUN, per edge: if A==B or A==0 or B==0, terminate; else if A>B then A<=A-B, else B<=B-A, step count +1.
REQ-021 Terminate result: A==0 and B==0 -> out_gcd 0, out_err 1; A==0 -> B; B==0 or A==B -> A, out_err 0; go DONE with out_valid 1, cycles <= step count.
REQ-022 If step count reaches MAX_STEPS in RUN without terminating: out_gcd 0, out_err 1, go DONE.
REQ-023 Latency: a job needing k subtractions SHALL raise out_valid on edge E0+k+1, E0 being the pop edge.
REQ-024 DONE: out_valid, out_gcd, out_err SHALL hold stable until out_ready high; on that edge go IDLE, out_valid 0, jobs_done +1.
REQ-025 Next pop SHALL occur no earlier than the edge after the DONE->IDLE edge; queue keeps accepting while engine is in RUN or DONE.
REQ-026 Comparisons and subtractions SHALL be unsigned WIDTH-bit; no result wider than WIDTH.
REQ-027 bsy SHALL be combinational from state and queue occupancy.

Reset
REQ-028 On rst edge: state IDLE, queue empty, in_ready 1, out_valid 0, out_gcd 0, out_err 0, cycles 0, jobs_done 0, bsy 0.
REQ-029 rst in RUN or DONE SHALL discard the current job and all queued jobs with no output.
REQ-030 rst SHALL override a simultaneous push or out_ready.

Structure
REQ-031 State encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) SHALL live in a shared package with the CPU's existing IDLE/RUN codes.
REQ-032 Job queue SHALL be a sub-module gcd_job_fifo (parameters WIDTH*2, DEPTH; push/pop/full/empty).
REQ-033 Datapath and FSM SHALL be in gcd_accel; no memories besides the queue.

Verification
REQ-034 Push (48,18), out_ready 1 -> 4 subtractions, out_valid on E0+5, out_gcd 6, out_err 0, cycles 4.
REQ-035 Push (0,7) then (0,0) -> results 7/err 0, then 0/err 1, in order, jobs_done 2.
REQ-036 MAX_STEPS 8, push (1,100) -> out_gcd 0, out_err 1 after 8 steps; following (9,6) -> 3.
REQ-037 out_ready 0, push DEPTH+2 jobs (5,5) -> in_ready low after DEPTH+1 accepted pushes (one in engine); result held stable; release -> all DEPTH+1 results returned.
REQ-038 Assert rst during RUN of (1000,1) with 2 queued -> next edge out_valid 0, bsy 0, in_ready 1, jobs_done 0; no stale result afterwards.
